// File: rtl/nand4_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand4_test_pkg
// Description : Shared types, sizes and the reference NAND function used by
//               the 4-input NAND self-test sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package nand4_test_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;
    localparam int ERR_W       = 5;
    // Settle counter must cover the full legal SETTLE_CYCLES range (1..255).
    localparam int CNT_W       = $clog2(256);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Reference output of an ideal 4-input NAND for vector {D,C,B,A}.
    function automatic logic nand4_expected(input logic [VEC_W-1:0] vec);
        return ~&vec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nand4_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : nand4_settle_timer
// Description : Loadable down-counter that times how long each test vector
//               is held before the gate output is sampled.
// Ports       : clk_i      - clock, rising edge
//               rst_ni     - asynchronous active-low reset
//               load_i     - load load_val_i (has priority over dec_i)
//               load_val_i - reload value
//               dec_i      - decrement by one (stops at zero)
//               zero_o     - counter is zero
// Revision    : 1.0 - initial release
// ============================================================================
module nand4_settle_timer
    import nand4_test_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/nand4_test_seq.sv
`default_nettype none
// ============================================================================
// Module      : nand4_test_seq
// Description : Self-test sequencer for a 4-input NAND gate. Walks all 16
//               input vectors, holds each for SETTLE_CYCLES, compares the
//               gate output X with the ideal NAND and reports the result.
// Ports       : CLK, RST_N        - clock / asynchronous active-low reset
//               START, ABORT      - run request / cancel
//               X                 - gate output under test
//               A, B, C, D        - gate inputs (vec[0..3])
//               BUSY, DONE, PASS  - run status
//               ERR_CNT           - mismatch count
//               FAIL_VALID/VEC    - first failing vector {D,C,B,A}
// Revision    : 1.0 - initial release
// ============================================================================
module nand4_test_seq
    import nand4_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic             X,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_VALID,
    output logic [VEC_W-1:0] FAIL_VEC
);

    // Counter reload value: SETTLE lasts load+1 cycles.
    localparam logic [CNT_W-1:0] C_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] C_LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fail_valid_q, fail_valid_d;
    logic [VEC_W-1:0]   fail_vec_q, fail_vec_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_zero;
    logic               mismatch;

    nand4_settle_timer u_settle_timer (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .load_i     (tmr_load),
        .load_val_i (C_SETTLE_LOAD),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign mismatch = (X != nand4_expected(vec_q));

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        pass_d       = pass_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    vec_d        = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                    tmr_load     = 1'b1;
                    state_d      = SETTLE;
                end
            end

            SETTLE: begin
                if (ABORT) begin
                    vec_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    state_d = CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            CHECK: begin
                // An abort in the compare cycle discards that compare.
                if (ABORT) begin
                    vec_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_vec_d   = vec_q;
                        end
                    end
                    if (vec_q == C_LAST_VEC) begin
                        // Registered DONE/PASS go live together with FINISH.
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                        state_d = FINISH;
                    end else begin
                        vec_d    = vec_q + 1'b1;
                        tmr_load = 1'b1;
                        state_d  = SETTLE;
                    end
                end
            end

            FINISH: begin
                // Vector stays at 4'b1111 after a completed run.
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            pass_q       <= pass_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign A          = vec_q[0];
    assign B          = vec_q[1];
    assign C          = vec_q[2];
    assign D          = vec_q[3];
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign PASS       = pass_q;
    assign ERR_CNT    = err_q;
    assign FAIL_VALID = fail_valid_q;
    assign FAIL_VEC   = fail_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_nand4_test_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand4_test_seq
// Description : Directed self-checking bench for nand4_test_seq. One instance
//               at the default settle time, one with SETTLE_CYCLES=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nand4_test_seq;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       START, ABORT, X;
    logic       A, B, C, D, BUSY, DONE, PASS, FAIL_VALID;
    logic [4:0] ERR_CNT;
    logic [3:0] FAIL_VEC;

    logic       START1, ABORT1, X1;
    logic       A1, B1, C1, D1, BUSY1, DONE1, PASS1, FAIL_VALID1;
    logic [4:0] ERR_CNT1;
    logic [3:0] FAIL_VEC1;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;   // 0 = ideal NAND, 1 = stuck at 1, 2 = stuck at 0
    int cyc;
    int dones;
    bit found;

    always #5 CLK = ~CLK;

    assign X  = (mode == 0) ? ~(A & B & C & D) : (mode == 1);
    assign X1 = ~(A1 & B1 & C1 & D1);

    nand4_test_seq #(.SETTLE_CYCLES(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .X(X),
        .A(A), .B(B), .C(C), .D(D), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .ERR_CNT(ERR_CNT), .FAIL_VALID(FAIL_VALID), .FAIL_VEC(FAIL_VEC)
    );

    nand4_test_seq #(.SETTLE_CYCLES(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .START(START1), .ABORT(ABORT1), .X(X1),
        .A(A1), .B(B1), .C(C1), .D(D1), .BUSY(BUSY1), .DONE(DONE1), .PASS(PASS1),
        .ERR_CNT(ERR_CNT1), .FAIL_VALID(FAIL_VALID1), .FAIL_VEC(FAIL_VEC1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: START is seen by the next rising edge only.
    task automatic pulse_start();
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    // Counts negedges until DONE is seen high; cycle 1 is the first one.
    task automatic wait_done(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge CLK);
            if (DONE) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_vec(input logic [3:0] v, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if ({D, C, B, A} == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; START1 = 1'b0; ABORT1 = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_vec",   {28'd0, D, C, B, A}, 32'h0);
        chk("rst_busy",  BUSY, 0);
        chk("rst_done",  DONE, 0);
        chk("rst_pass",  PASS, 0);
        chk("rst_err",   ERR_CNT, 0);
        chk("rst_fv",    FAIL_VALID, 0);
        chk("rst_fvec",  FAIL_VEC, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        // 1: ideal gate, check the vector walk and the 49-cycle latency.
        mode = 0;
        pulse_start();
        for (int c = 1; c <= 49; c++) begin
            @(negedge CLK);
            if (c <= 48) chk("t1_walk", {28'd0, D, C, B, A}, (c - 1) / 3);
            chk("t1_done", DONE, (c == 49));
        end
        chk("t1_pass", PASS, 1);
        chk("t1_err",  ERR_CNT, 0);
        chk("t1_fv",   FAIL_VALID, 0);
        chk("t1_busy_fin", BUSY, 1);
        chk("t1_vec_fin", {28'd0, D, C, B, A}, 32'hF);
        @(negedge CLK);
        chk("t1_busy_idle", BUSY, 0);
        chk("t1_done_idle", DONE, 0);
        chk("t1_vec_idle", {28'd0, D, C, B, A}, 32'hF);

        // 2: X stuck at 1, only vector 15 mismatches.
        mode = 1;
        pulse_start();
        wait_done(80, cyc);
        chk("t2_lat",  cyc, 49);
        chk("t2_pass", PASS, 0);
        chk("t2_err",  ERR_CNT, 1);
        chk("t2_fv",   FAIL_VALID, 1);
        chk("t2_fvec", FAIL_VEC, 4'hF);
        @(negedge CLK);

        // 3: X stuck at 0, vectors 0..14 mismatch; then an ideal rerun.
        mode = 2;
        pulse_start();
        wait_done(80, cyc);
        chk("t3_lat",  cyc, 49);
        chk("t3_pass", PASS, 0);
        chk("t3_err",  ERR_CNT, 15);
        chk("t3_fvec", FAIL_VEC, 4'h0);
        chk("t3_fv",   FAIL_VALID, 1);
        @(negedge CLK);
        chk("t3_hold_err", ERR_CNT, 15);
        mode = 0;
        pulse_start();
        @(negedge CLK);
        chk("t3_clr_err", ERR_CNT, 0);
        chk("t3_clr_fv",  FAIL_VALID, 0);
        chk("t3_busy",    BUSY, 1);
        wait_done(80, cyc);
        chk("t3_rerun_lat", cyc + 1, 49);
        chk("t3_rerun_pass", PASS, 1);
        chk("t3_rerun_err",  ERR_CNT, 0);
        @(negedge CLK);

        // 4: START while busy is ignored; ABORT at vec 5 keeps partial counts.
        mode = 2;
        pulse_start();
        wait_vec(4'd2, 40, found);
        chk("t4_reach2", found, 1);
        pulse_start();
        @(negedge CLK);
        chk("t4_nostart_vec", {28'd0, D, C, B, A}, 32'h2);
        chk("t4_nostart_err", ERR_CNT, 2);
        chk("t4_busy", BUSY, 1);
        wait_vec(4'd5, 40, found);
        chk("t4_reach5", found, 1);
        ABORT = 1'b1;
        @(posedge CLK);
        #1 ABORT = 1'b0;
        @(negedge CLK);
        chk("t4_busy0", BUSY, 0);
        chk("t4_vec0",  {28'd0, D, C, B, A}, 32'h0);
        chk("t4_err",   ERR_CNT, 5);
        chk("t4_fv",    FAIL_VALID, 1);
        chk("t4_fvec",  FAIL_VEC, 0);
        chk("t4_pass",  PASS, 0);
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (DONE || BUSY) dones++;
        end
        chk("t4_no_done", dones, 0);

        // 5: asynchronous reset mid-run at vec 9.
        mode = 2;
        pulse_start();
        wait_vec(4'd9, 60, found);
        chk("t5_reach9", found, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("t5_vec",  {28'd0, D, C, B, A}, 32'h0);
        chk("t5_busy", BUSY, 0);
        chk("t5_err",  ERR_CNT, 0);
        chk("t5_fv",   FAIL_VALID, 0);
        chk("t5_done", DONE, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("t5_idle_busy", BUSY, 0);
        mode = 0;
        pulse_start();
        wait_done(80, cyc);
        chk("t5_lat",  cyc, 49);
        chk("t5_pass", PASS, 1);
        chk("t5_err2", ERR_CNT, 0);
        @(negedge CLK);

        // 6: SETTLE_CYCLES=1 instance; START with ABORT is ignored first.
        START1 = 1'b1; ABORT1 = 1'b1;
        @(posedge CLK);
        #1 START1 = 1'b0; ABORT1 = 1'b0;
        @(negedge CLK);
        chk("t6_ign_busy", BUSY1, 0);
        @(negedge CLK);
        chk("t6_ign_busy2", BUSY1, 0);
        START1 = 1'b1;
        @(posedge CLK);
        #1 START1 = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge CLK);
            if (c <= 32) chk("t6_walk", {28'd0, D1, C1, B1, A1}, (c - 1) / 2);
            chk("t6_done", DONE1, (c == 33));
        end
        chk("t6_pass", PASS1, 1);
        chk("t6_err",  ERR_CNT1, 0);
        chk("t6_fv",   FAIL_VALID1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
